// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants used by the fetch
// stage and the immediate generator, the canonical NOP and fetch FSM states.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {inst, pc} buffer: the head is the output slot seen by decode,
// the second entry is the skid that catches a response arriving while decode
// is stalled. Flush empties both entries.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc,
  input  logic        pop,
  output logic        head_valid,
  output logic [31:0] head_inst,
  output logic [31:0] head_pc,
  output logic        skid_valid
);

  logic        head_valid_q, head_valid_d;
  logic [31:0] head_inst_q,  head_inst_d;
  logic [31:0] head_pc_q,    head_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q,  skid_inst_d;
  logic [31:0] skid_pc_q,    skid_pc_d;

  // Next-state of both entries: flush wins, then pop/push ordering.
  always_comb begin
    head_valid_d = head_valid_q;
    head_inst_d  = head_inst_q;
    head_pc_d    = head_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && head_valid_q) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_inst_d  = skid_inst_q;
        head_pc_d    = skid_pc_q;
        skid_valid_d = push;
        if (push) begin
          skid_inst_d = push_inst;
          skid_pc_d   = push_pc;
        end
      end else if (push) begin
        head_valid_d = 1'b1;
        head_inst_d  = push_inst;
        head_pc_d    = push_pc;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_inst_d  = push_inst;
        head_pc_d    = push_pc;
      end else if (!skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = push_inst;
        skid_pc_d    = push_pc;
      end
      // Both full cannot take a push: fetch never requests with the skid full.
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_inst_q  <= NOP_INST;
      head_pc_q    <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= RESET_PC;
    end else begin
      head_valid_q <= head_valid_d;
      head_inst_q  <= head_inst_d;
      head_pc_q    <= head_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_inst  = head_inst_q;
  assign head_pc    = head_pc_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage with one outstanding memory request.
// Handshakes: a memory request transfers in a cycle where imem_req && imem_ready;
// imem_req is not held once accepted. imem_rvalid returns the single
// outstanding response one or more cycles later. Decode consumes the output
// in a cycle where inst_valid && !stall; while stalled, inst/pc stay stable.
// A redirect flushes buffered instructions; a response still in flight at that
// point is marked killed and dropped when it returns, before the redirect
// target is requested.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         kill_q, kill_d;

  logic         buf_valid;
  logic [31:0]  buf_inst;
  logic [31:0]  buf_pc;
  logic         skid_full;
  logic         accept;
  logic         pop;
  logic         push;
  logic         unused_redirect_lsbs;

  // Target bits [1:0] are ignored; redirects are always word aligned.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request only in REQ, with room for the response and no killed response pending.
  assign imem_req  = !rst && (state_q == REQ) && !skid_full && !kill_q;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // A live response lands only in WAIT, never in a redirect cycle.
  assign push = imem_rvalid && (state_q == WAIT) && !kill_q && !redirect_valid;
  assign pop  = buf_valid && !stall && !redirect_valid;

  // Fetch FSM next state, fetch address and kill flag; redirect has priority.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if (redirect_valid) begin
      state_d    = REQ;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      kill_d     = (((state_q == WAIT) || kill_q) && !imem_rvalid) || accept;
    end else begin
      if (kill_q && imem_rvalid) begin
        kill_d = 1'b0;
      end
      case (state_q)
        REQ: begin
          if (accept) begin
            state_d    = WAIT;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // FSM, fetch address and kill flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
    end
  end

  fetch_buffer #(
    .RESET_PC (RESET_PC)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_inst  (imem_rdata),
    .push_pc    (fetch_pc_q - 32'd4),
    .pop        (pop),
    .head_valid (buf_valid),
    .head_inst  (buf_inst),
    .head_pc    (buf_pc),
    .skid_valid (skid_full)
  );

  assign inst_valid = buf_valid;
  assign inst       = buf_valid ? buf_inst : NOP_INST;
  assign pc         = buf_pc;
  assign pc_plus4   = buf_pc + 32'd4;

endmodule
